// File: rtl/wb_pkg.sv
// Shared types and constants for the Dioptase writeback stage.
package wb_pkg;
  typedef enum logic [1:0] {LD_B = 2'd0, LD_H = 2'd1, LD_W = 2'd2, LD_D = 2'd3} ld_size_t;
  typedef enum logic {IDLE = 1'b0, HI = 1'b1} wb_state_t;
  localparam int REG_IDX_W = 5;
endpackage

// File: rtl/wb_stage_gen_load_extract.sv
// Combinational load aligner: shifts a two-word window by the byte offset,
// truncates to the access size and sign/zero-extends to DATA_W.
module load_extract
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic [2*DATA_W-1:0] win,
  input  logic [OFF_W-1:0]    off,
  input  logic [1:0]          size,
  input  logic                sgn,
  output logic [DATA_W-1:0]   res,
  output logic                size_err
);

  logic [DATA_W-1:0] shifted;
  logic              fill;
  int                nbits;

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v, input int nb,
                                               input logic f);
    logic [DATA_W-1:0] mask;
    mask = ~({DATA_W{1'b1}} << nb);
    return (v & mask) | ({DATA_W{f}} & ~mask);
  endfunction

  assign shifted = DATA_W'(win >> {off, 3'b000});

  always_comb begin
    size_err = 1'b0;
    fill     = 1'b0;
    nbits    = DATA_W;
    case (size)
      LD_B: begin nbits = 8;  fill = shifted[7];  end
      LD_H: begin nbits = 16; fill = shifted[15]; end
      LD_W: begin nbits = 32; fill = shifted[31]; end
      default: begin
        // A dword only exists on the 64-bit datapath.
        nbits    = DATA_W;
        fill     = shifted[DATA_W-1];
        size_err = (DATA_W < 64);
      end
    endcase
    res = size_err ? '0 : extend(shifted, nbits, sgn & fill);
  end

endmodule

// File: rtl/wb_stage_gen.sv
// Writeback stage: load alignment/merge for split loads, per-port write
// enables and registered forwarding copies of every write port.
module wb_stage_gen
  import wb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NPORTS   = 2,
  parameter int SIGN_EXT = 1,
  localparam int OFF_W   = $clog2(DATA_W / 8)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic                          valid,
  input  logic                          bubble,
  input  logic                          is_load,
  input  logic                          split,
  input  logic [1:0]                    ld_size,
  input  logic                          ld_signed,
  input  logic [OFF_W-1:0]              addr_off,
  input  logic [DATA_W-1:0]             mem_data,
  input  logic [NPORTS-1:0]             we_req,
  input  logic [REG_IDX_W*NPORTS-1:0]   tgt_in,
  input  logic [DATA_W*NPORTS-1:0]      alu_in,
  output logic [NPORTS-1:0]             we,
  output logic [DATA_W*NPORTS-1:0]      result_out,
  output logic [NPORTS-1:0]             wb_we,
  output logic [REG_IDX_W*NPORTS-1:0]   wb_tgt,
  output logic [DATA_W*NPORTS-1:0]      wb_data,
  output logic                          split_busy,
  output logic                          proto_err
);

  wb_state_t             state;
  logic [DATA_W-1:0]     lo_buf;
  logic [OFF_W-1:0]      off_q;
  ld_size_t              size_q;
  logic                  sgn_q;

  logic                  live, ld_split, second, misuse, start;
  logic [2*DATA_W-1:0]   win;
  logic [OFF_W-1:0]      off_sel;
  logic [1:0]            size_sel;
  logic                  sgn_sel;
  logic [DATA_W-1:0]     ext_res;
  logic                  size_err;

  assign live     = valid & ~bubble & ~stall;
  assign ld_split = live & is_load & split;
  assign second   = (state == HI) & ld_split;
  assign misuse   = (state == HI) & live & ~ld_split;
  // A split that is not a second half opens a new pair, including after a misuse.
  assign start    = ld_split & ~second;

  always_comb begin
    if (second) begin
      win      = {mem_data, lo_buf};
      off_sel  = off_q;
      size_sel = size_q;
      sgn_sel  = sgn_q;
    end else begin
      win      = {{DATA_W{1'b0}}, mem_data};
      off_sel  = addr_off;
      size_sel = ld_size;
      sgn_sel  = ld_signed;
    end
  end

  load_extract #(.DATA_W(DATA_W)) u_extract (
    .win      (win),
    .off      (off_sel),
    .size     (size_sel),
    .sgn      (sgn_sel & (SIGN_EXT != 0)),
    .res      (ext_res),
    .size_err (size_err)
  );

  assign proto_err  = misuse | (live & is_load & ~start & size_err);
  assign split_busy = (state == HI);

  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      we[p] = live & we_req[p] & (tgt_in[p*REG_IDX_W +: REG_IDX_W] != '0);
      result_out[p*DATA_W +: DATA_W] = alu_in[p*DATA_W +: DATA_W];
    end
    we[0] = we[0] & ~start;
    if (is_load) result_out[DATA_W-1:0] = ext_res;
  end

  // Stage boundary: FSM, split buffer and forwarding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      lo_buf <= '0;
      off_q  <= '0;
      size_q <= LD_B;
      sgn_q  <= 1'b0;
      wb_we  <= '0;
      wb_tgt <= '0;
      wb_data <= '0;
    end else if (!stall) begin
      if (start) begin
        state  <= HI;
        lo_buf <= mem_data;
        off_q  <= addr_off;
        size_q <= ld_size_t'(ld_size);
        sgn_q  <= ld_signed;
      end else if (live) begin
        state <= IDLE;
      end
      wb_we   <= we;
      wb_tgt  <= tgt_in;
      wb_data <= result_out;
    end
  end

endmodule
